// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor: out = a - b, computed LSB first as
// a + ~b + 1 over DATA_WIDTH_OUT cycles with a valid/ready handshake on
// both sides. Operands are sign-extended to DATA_WIDTH_OUT on capture.
// DATA_WIDTH_OUT must be at least 2; DATA_WIDTH_A/B must not exceed it.
module serial_subtractor #(
  parameter int DATA_WIDTH_A   = 8,
  parameter int DATA_WIDTH_B   = 8,
  parameter int DATA_WIDTH_OUT = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [DATA_WIDTH_A-1:0]   i_a,
  input  logic [DATA_WIDTH_B-1:0]   i_b,
  output logic [DATA_WIDTH_OUT-1:0] o_out,
  output logic                      o_overflow,
  output logic                      o_out_valid,
  input  logic                      i_out_ready
);

  localparam int W  = DATA_WIDTH_OUT;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Full-adder carry: majority of the three inputs.
  function automatic logic majority(input logic x, input logic y, input logic z);
    majority = (x & y) | (x & z) | (y & z);
  endfunction

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic [W-1:0]    r_out;
  logic            r_overflow;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;

  logic signed [DATA_WIDTH_A-1:0] w_a_sgn;
  logic signed [DATA_WIDTH_B-1:0] w_b_sgn;
  logic [W-1:0]    w_a_ext;
  logic [W-1:0]    w_b_ext;
  logic            w_a_bit;
  logic            w_nb_bit;
  logic            w_d;
  logic            w_carry_next;
  logic            w_last;

  // Sign extension of the raw operands to the result width.
  assign w_a_sgn = i_a;
  assign w_b_sgn = i_b;
  assign w_a_ext = W'(w_a_sgn);
  assign w_b_ext = W'(w_b_sgn);

  // One full-adder slice: a_i + ~b_i + carry.
  assign w_a_bit      = r_a[r_cnt];
  assign w_nb_bit     = ~r_b[r_cnt];
  assign w_d          = w_a_bit ^ w_nb_bit ^ r_carry;
  assign w_carry_next = majority(w_a_bit, w_nb_bit, r_carry);
  assign w_last       = (r_cnt == LAST_BIT);

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out       = r_out;
  assign o_overflow  = r_overflow;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; handshakes outside their own state are ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_state_next = S_BUSY;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_BUSY;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, serial add, result/overflow latch, handshake flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_res       <= {W{1'b0}};
      r_out       <= {W{1'b0}};
      r_overflow  <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_a     <= w_a_ext;
            r_b     <= w_b_ext;
            r_res   <= {W{1'b0}};
            r_carry <= 1'b1;
            r_cnt   <= {CW{1'b0}};
          end
        end
        S_BUSY: begin
          r_carry <= w_carry_next;
          r_res   <= {w_d, r_res[W-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // The bit produced now is the result's sign bit.
            r_out      <= {w_d, r_res[W-1:1]};
            r_overflow <= (r_a[W-1] != r_b[W-1]) && (w_d != r_a[W-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: SerialSubtractor

Interface
REQ-001 SHALL have parameter DATA_WIDTH_A, default 8: width of signed operand a.
REQ-002 SHALL have parameter DATA_WIDTH_B, default 8: width of signed operand b.
REQ-003 SHALL have parameter DATA_WIDTH_OUT, default 8: width of signed result; DATA_WIDTH_A and DATA_WIDTH_B SHALL each be <= DATA_WIDTH_OUT.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operands a, b presented.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  DATA_WIDTH_A  signed minuend.
REQ-009 b  input  DATA_WIDTH_B  signed subtrahend.
REQ-010 out  output  DATA_WIDTH_OUT  signed difference a - b, truncated to DATA_WIDTH_OUT.
REQ-011 overflow  output  1  true difference not representable in DATA_WIDTH_OUT bits.
REQ-012 out_valid  output  1  out and overflow are valid.
REQ-013 out_ready  input  1  consumer accepts result.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a rising edge, SHALL capture a and b sign-extended to DATA_WIDTH_OUT, set carry=1, bit counter=0, enter BUSY.
REQ-016 BUSY: in_ready=0; each cycle SHALL process one bit i, LSB first: d_i = a_i XOR (NOT b_i) XOR carry; carry = majority(a_i, NOT b_i, carry); d_i shifted into result register.
REQ-017 BUSY SHALL last exactly DATA_WIDTH_OUT cycles; on the edge processing bit DATA_WIDTH_OUT-1 SHALL enter DONE.
REQ-018 Latency: operands accepted at edge k -> out_valid=1 after edge k+DATA_WIDTH_OUT.
REQ-019 overflow SHALL be computed at DONE entry: (sign(a_ext) != sign(b_ext)) AND (sign(out) != sign(a_ext)).
REQ-020 DONE: out_valid=1, in_ready=0; out and overflow SHALL remain stable until out_ready=1 at a rising edge, then return to IDLE (out_valid=0 next cycle).
REQ-021 No overlap: a new operand pair SHALL only be accepted in IDLE; in_valid during BUSY or DONE SHALL be ignored and SHALL NOT alter captured operands.
REQ-022 out SHALL hold its last value in IDLE until the next DONE entry updates it; out is only meaningful while out_valid=1.
REQ-023 out_ready asserted while not in DONE SHALL have no effect.
REQ-024 Arithmetic SHALL be two's complement modulo 2^DATA_WIDTH_OUT; no saturation.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force IDLE, in_ready=1, out_valid=0, out=0, overflow=0, carry=0, counter=0, operand registers=0.
REQ-026 rst asserted in BUSY or DONE SHALL abort the operation; no result for it SHALL ever appear.
REQ-027 First operand acceptance SHALL occur no earlier than the first rising edge after rst deasserts.

Verification (DATA_WIDTH_A=B=OUT=8)
REQ-028 a=5, b=3, in_valid 1 cycle, out_ready=1 -> out_valid high 8 cycles after accept, out=2, overflow=0, one-cycle out_valid.
REQ-029 a=-128, b=1 -> out=127, overflow=1; a=127, b=-1 -> out=-128, overflow=1.
REQ-030 a=0, b=0 and a=-1, b=-1 -> out=0, overflow=0; a=3, b=5 -> out=-2 (0xFE), overflow=0.
REQ-031 a=10, b=4, out_ready held 0 for 5 cycles after out_valid -> out=6 stable throughout, in_ready=0, return to IDLE one edge after out_ready=1.
REQ-032 in_valid with a=1, b=1 asserted during BUSY of a=20, b=7 -> out=13, second pair never processed.
REQ-033 rst pulsed 3 cycles into BUSY -> out_valid=0, out=0, in_ready=1 immediately; subsequent a=9, b=2 -> out=7 after 8 cycles.
